// File: rtl/shf_seq_d4c3_if.sv
// Handshake and shifter-facing bundle for the shift sequencer.
// slave = sequencer side, master = requester/consumer/shifter side.
interface shf_seq_d4c3_if #(
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_d;
    logic [2:0]       in_op;
    logic [CNT_W-1:0] in_cnt;
    logic [3:0]       shf_d;
    logic [2:0]       shf_s;
    logic [3:0]       shf_y;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_q;
    logic             busy;

    modport slave (
        input  in_valid, in_d, in_op, in_cnt, shf_y, out_ready,
        output in_ready, shf_d, shf_s, out_valid, out_q, busy
    );

    modport master (
        output in_valid, in_d, in_op, in_cnt, shf_y, out_ready,
        input  in_ready, shf_d, shf_s, out_valid, out_q, busy
    );
endinterface

// File: rtl/shf_seq_d4c3.sv
// Multi-cycle shift sequencer: feeds an external combinational 4-bit shifter
// from its accumulator and folds the result back once per cycle, cnt times.
module shf_seq_d4c3 #(
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    shf_seq_d4c3_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       acc_q, acc_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 4'd0;
            op_q    <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = bus.in_d;
                    op_d    = bus.in_op;
                    cnt_d   = bus.in_cnt;
                    state_d = (bus.in_cnt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Exiting at cnt==1 keeps the decrement from ever wrapping.
                acc_d = bus.shf_y;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.shf_d     = acc_q;
    assign bus.shf_s     = op_q;
    assign bus.out_q     = acc_q;
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
endmodule
